ram_pattern_writer: RTL and testbench

//  Write side of the RAM test harness: fills the dual-bank RAM with the even/odd bank pattern

---
 rtl/ram_test_pkg.sv | 25 ++
 rtl/ram_expect_pipe.sv | 36 +++
 rtl/ram_pattern_writer.sv | 200 ++++++++++++++++++++
 tb/tb_ram_pattern_writer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ram_test_pkg.sv
// Shared state, pattern and address helpers for the RAM test harness.
// Used by ram_pattern_writer (readback build: RAM_WRITER_READBACK_EN).
package ram_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    VERIFY,
    DONE
  } state_t;

  localparam logic [7:0] EVEN_WORD = 8'hFF;
  localparam logic [7:0] ODD_WORD  = 8'h00;

  // Sweep index LSB becomes the bank bit (address MSB).
  function automatic logic [31:0] bank_ilv(
    input logic [31:0] idx,
    input int unsigned aw
  );
    logic [31:0] hi;
    hi = {31'b0, idx[0]} << (aw - 1);
    return (idx >> 1) | hi;
  endfunction

endpackage

// File: rtl/ram_expect_pipe.sv
// Expected-word/valid delay line aligning readback compares with RAM q.
// Used by ram_pattern_writer when RAM_WRITER_READBACK_EN is defined.
module ram_expect_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     dat [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++)
        dat[i] <= '0;
    end else begin
      vld[0] <= in_vld;
      dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_vld  = vld[DEPTH-1];
  assign out_data = dat[DEPTH-1];

endmodule

// File: rtl/ram_pattern_writer.sv
// Fills the dual-bank RAM with the bank pattern, bank bit toggling each write.
// Optional readback pass: define RAM_WRITER_READBACK_EN.
module ram_pattern_writer
  import ram_test_pkg::*;
#(
  parameter int                ADDR_W       = 10,
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] EVEN_PATTERN = DATA_W'(EVEN_WORD),
  parameter logic [DATA_W-1:0] ODD_PATTERN  = DATA_W'(ODD_WORD),
  parameter int                READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              invert,
`ifdef RAM_WRITER_READBACK_EN
  input  logic [DATA_W-1:0] q,
  output logic              error,
`endif
  output logic              busy,
  output logic              done,
  output logic              clk_enable,
  output logic [ADDR_W-1:0] address,
  output logic              wren,
  output logic [DATA_W-1:0] data_to_write
);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cnt, cnt_nx;
  logic                last, last_nx;
  logic                inv, inv_nx;
  logic                busy_nx, done_nx, wren_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   data_nx;

  function automatic logic [DATA_W-1:0] pat(
    input logic bank,
    input logic inv_i
  );
    return (bank ? ODD_PATTERN : EVEN_PATTERN) ^ {DATA_W{inv_i}};
  endfunction

  function automatic logic [ADDR_W-1:0] ilv(
    input logic [ADDR_W-1:0] c
  );
    return ADDR_W'(bank_ilv(32'(c), ADDR_W));
  endfunction

`ifdef RAM_WRITER_READBACK_EN
  logic              rd_vld, rd_vld_nx;
  logic              rd_lst, rd_lst_nx;
  logic [DATA_W-1:0] rd_exp, rd_exp_nx;
  logic              err_nx;
  logic              chk_vld;
  logic [DATA_W:0]   chk_data;
  logic              chk_lst;
  logic [DATA_W-1:0] chk_exp;

  ram_expect_pipe #(
    .DEPTH (READ_LATENCY),
    .W     (DATA_W + 1)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (rd_vld),
    .in_data  ({rd_lst, rd_exp}),
    .out_vld  (chk_vld),
    .out_data (chk_data)
  );

  assign chk_lst = chk_data[DATA_W];
  assign chk_exp = chk_data[DATA_W-1:0];
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    inv_nx   = inv;
    busy_nx  = busy;
    done_nx  = done;
    wren_nx  = 1'b0;
    addr_nx  = address;
    data_nx  = data_to_write;
`ifdef RAM_WRITER_READBACK_EN
    rd_vld_nx = 1'b0;
    rd_lst_nx = 1'b0;
    rd_exp_nx = rd_exp;
    err_nx    = error | (chk_vld && (q != chk_exp));
`endif
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = FILL;
          inv_nx   = invert;
          cnt_nx   = '0;
          last_nx  = 1'b0;
          done_nx  = 1'b0;
          busy_nx  = 1'b1;
`ifdef RAM_WRITER_READBACK_EN
          err_nx   = 1'b0;
`endif
        end
      end
      FILL: begin
        if (!last) begin
          addr_nx = ilv(cnt);
          wren_nx = 1'b1;
          data_nx = pat(cnt[0], inv);
          if (cnt == '1) last_nx = 1'b1;
          else           cnt_nx  = cnt + 1'b1;
        end else begin
          last_nx = 1'b0;
          data_nx = '0;
`ifdef RAM_WRITER_READBACK_EN
          // First read goes out on the same edge FILL retires.
          state_nx  = VERIFY;
          addr_nx   = '0;
          rd_vld_nx = 1'b1;
          rd_exp_nx = pat(1'b0, inv);
          cnt_nx    = ADDR_W'(1);
`else
          state_nx = DONE;
          cnt_nx   = '0;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
`endif
        end
      end
      VERIFY: begin
`ifdef RAM_WRITER_READBACK_EN
        if (!last) begin
          addr_nx   = ilv(cnt);
          rd_vld_nx = 1'b1;
          rd_exp_nx = pat(cnt[0], inv);
          if (cnt == '1) begin
            last_nx   = 1'b1;
            rd_lst_nx = 1'b1;
            cnt_nx    = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        if (chk_vld && chk_lst) begin
          state_nx = DONE;
          last_nx  = 1'b0;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      last          <= 1'b0;
      inv           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      wren          <= 1'b0;
      address       <= '0;
      data_to_write <= '0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      last          <= last_nx;
      inv           <= inv_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      wren          <= wren_nx;
      address       <= addr_nx;
      data_to_write <= data_nx;
    end
  end

`ifdef RAM_WRITER_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld <= 1'b0;
      rd_lst <= 1'b0;
      rd_exp <= '0;
      error  <= 1'b0;
    end else begin
      rd_vld <= rd_vld_nx;
      rd_lst <= rd_lst_nx;
      rd_exp <= rd_exp_nx;
      error  <= err_nx;
    end
  end
`endif

  assign clk_enable = busy;

endmodule

// File: tb/tb_ram_pattern_writer.sv
// Directed bench for ram_pattern_writer with a write scoreboard.
// Readback checks build when RAM_WRITER_READBACK_EN is defined.
module tb_ram_pattern_writer;

  localparam int NW = 1024;
`ifdef RAM_WRITER_READBACK_EN
  localparam int EXP_DONE = 1026 + 1026;
`else
  localparam int EXP_DONE = 1026;
`endif

  logic       clk = 1'b0;
  logic       reset, start, invert;
  logic       busy, done, clk_enable, wren;
  logic [9:0] address;
  logic [7:0] data_to_write;
  logic       corrupt_req;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t sb[$];
  int  tests = 0;
  int  fails = 0;

`ifdef RAM_WRITER_READBACK_EN
  logic [7:0] q;
  logic       error;
  logic [7:0] mem [NW];
  logic [7:0] s1;

  always @(posedge clk) begin
    if (wren) mem[address] <= data_to_write;
    if (corrupt_req) mem[513] <= mem[513] ^ 8'h08;
    s1 <= mem[address];
    q  <= s1;
  end
`endif

  ram_pattern_writer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .invert        (invert),
`ifdef RAM_WRITER_READBACK_EN
    .q             (q),
    .error         (error),
`endif
    .busy          (busy),
    .done          (done),
    .clk_enable    (clk_enable),
    .address       (address),
    .wren          (wren),
    .data_to_write (data_to_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wren === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_wren", 32'(wren), 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(address), 32'(e.a));
        check("wr_data", 32'(data_to_write), 32'(e.d));
      end
    end
  end

  task automatic push_fill(input logic inv);
    sb.delete();
    for (int i = 0; i < NW; i++) begin
      wr_t e;
      e.a = 10'((i % 2) * 512 + i / 2);
      e.d = ((i % 2) ? 8'h00 : 8'hFF) ^ (inv ? 8'hFF : 8'h00);
      sb.push_back(e);
    end
  endtask

  task automatic run_fill(input logic inv, input int pulse_at,
                          input int corrupt_at, input int exp_done);
    int k;
    push_fill(inv);
    start  = 1'b1;
    invert = inv;
    @(negedge clk);
    start  = 1'b0;
    invert = 1'b0;
    k = 1;
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_clken", 32'(clk_enable), 32'd1);
    check("acc_wren", 32'(wren), 32'd0);
    check("acc_done", 32'(done), 32'd0);
`ifdef RAM_WRITER_READBACK_EN
    check("acc_err", 32'(error), 32'd0);
`endif
    while (done !== 1'b1 && k < exp_done + 50) begin
      @(negedge clk);
      k++;
      start       = 1'b0;
      corrupt_req = 1'b0;
      if (k == pulse_at) begin
        start  = 1'b1;
        invert = ~inv;
      end
      if (k == corrupt_at) corrupt_req = 1'b1;
    end
    start       = 1'b0;
    corrupt_req = 1'b0;
    check("done_cycle", 32'(k), 32'(exp_done));
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
`ifdef RAM_WRITER_READBACK_EN
    check("err_end", 32'(error), (corrupt_at > 0) ? 32'd1 : 32'd0);
`endif
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    invert      = 1'b0;
    corrupt_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_clken", 32'(clk_enable), 32'd0);
    check("rst_addr", 32'(address), 32'd0);
    check("rst_data", 32'(data_to_write), 32'd0);
`ifdef RAM_WRITER_READBACK_EN
    check("rst_err", 32'(error), 32'd0);
`endif

    run_fill(1'b0, -1, -1, EXP_DONE);
    repeat (5) @(negedge clk);
    check("done_hold", 32'(done), 32'd1);
    check("wren_idle", 32'(wren), 32'd0);

    run_fill(1'b1, 102, -1, EXP_DONE);

    push_fill(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (301) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_wren", 32'(wren), 32'd0);
    check("abort_addr", 32'(address), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    sb.delete();

    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("rst_win_busy", 32'(busy), 32'd0);
    check("rst_win_wren", 32'(wren), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_win_idle", 32'(busy), 32'd0);

    run_fill(1'b0, -1, -1, EXP_DONE);

`ifdef RAM_WRITER_READBACK_EN
    run_fill(1'b0, -1, 500, EXP_DONE);
    repeat (10) @(negedge clk);
    check("err_sticky", 32'(error), 32'd1);
    run_fill(1'b0, -1, -1, EXP_DONE);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
